// File: rtl/multi_priority_encoder.sv
// Serialising priority encoder: captures a request vector and emits the index of
// every set bit, one beat per handshake, in MSB-first or LSB-first order.
module multi_priority_encoder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] p_q;

    logic [IDX_W-1:0] pick;
    logic [WIDTH-1:0] clr_mask;
    logic             emit;
    logic             p_zero;
    logic             p_single;
    logic             last_beat;

    // Later matches overwrite earlier ones, so the scan direction sets the priority.
    function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (v[i]) idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        emit      = (state_q == EMIT);
        pick      = pick_index(p_q);
        clr_mask  = WIDTH'(1) << pick;
        p_zero    = (p_q == '0);
        p_single  = !p_zero && ((p_q & (p_q - WIDTH'(1))) == '0);
        last_beat = p_single || p_zero;

        in_ready  = !emit;
        busy      = emit;
        out_valid = emit;
        out       = emit ? pick : '0;
        out_last  = emit && last_beat;
        out_none  = emit && p_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        p_q     <= in;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_beat) begin
                            p_q     <= '0;
                            state_q <= IDLE;
                        end else begin
                            p_q <= p_q & ~clr_mask;
                        end
                    end
                end
                default: begin
                    p_q     <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_priority_encoder.sv
// Directed bench for multi_priority_encoder: three instances cover 8-bit MSB-first,
// 8-bit LSB-first and 16-bit MSB-first configurations.
module tb_multi_priority_encoder;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_none, a_busy;
    logic [7:0] a_in;
    logic [2:0] a_out;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_none, b_busy;
    logic [7:0] b_in;
    logic [2:0] b_out;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_last, c_out_none, c_busy;
    logic [15:0] c_in;
    logic [3:0]  c_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in(a_in), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out(a_out),
        .out_last(a_out_last), .out_none(a_out_none), .busy(a_busy)
    );

    multi_priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in(b_in), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out(b_out),
        .out_last(b_out_last), .out_none(b_out_none), .busy(b_busy)
    );

    multi_priority_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in(c_in), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_ready(out_ready), .out(c_out),
        .out_last(c_out_last), .out_none(c_out_none), .busy(c_busy)
    );

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1;
        a_in = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out !== 3'd0 ||
            a_out_last !== 1'b0 || a_out_none !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got rdy=%b vld=%b out=%0d last=%b none=%b busy=%b want 1 0 0 0 0 0",
                     a_in_ready, a_out_valid, a_out, a_out_last, a_out_none, a_busy);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc got b_rdy=%b b_vld=%b c_rdy=%b c_vld=%b want 1 0 1 0",
                     b_in_ready, b_out_valid, c_in_ready, c_out_valid);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept got vld=%b busy=%b want 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_msb_first();
        int exp_idx[4];
        exp_idx = '{7, 5, 2, 0};
        out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in = 8'b1010_0101;
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out !== exp_idx[k] || a_out_last !== (k == 3) ||
                a_out_none !== 1'b0 || a_in_ready !== 1'b0 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL msb_beat%0d got vld=%b out=%0d last=%b none=%b rdy=%b busy=%b want 1 %0d %0d 0 0 1",
                         k, a_out_valid, a_out, a_out_last, a_out_none, a_in_ready, a_busy, exp_idx[k], (k == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out !== 3'd0 || a_out_last !== 1'b0) begin
            errors++;
            $display("FAIL msb_idle got rdy=%b vld=%b out=%0d last=%b want 1 0 0 0",
                     a_in_ready, a_out_valid, a_out, a_out_last);
        end
    endtask

    task automatic test_ignore_in_emit();
        out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in = 8'h81;
        @(negedge clk);
        a_in = 8'hFF;
        checks++;
        if (a_out !== 3'd7 || a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL emit_beat0 got out=%0d last=%b rdy=%b want 7 0 0", a_out, a_out_last, a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 3'd0 || a_out_last !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL emit_beat1 got vld=%b out=%0d last=%b rdy=%b want 1 0 1 0",
                     a_out_valid, a_out, a_out_last, a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL emit_ignored got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_lsb_stall();
        out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_in = 8'b1000_0001;
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out !== 3'd0 || b_out_last !== 1'b0) begin
            errors++;
            $display("FAIL lsb_beat0 got vld=%b out=%0d last=%b want 1 0 0", b_out_valid, b_out, b_out_last);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out !== 3'd7 || b_out_last !== 1'b1) begin
            errors++;
            $display("FAIL lsb_beat1 got vld=%b out=%0d last=%b want 1 7 1", b_out_valid, b_out, b_out_last);
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (b_out_valid !== 1'b1 || b_out !== 3'd7 || b_out_last !== 1'b1 || b_out_none !== 1'b0) begin
            errors++;
            $display("FAIL lsb_stall got vld=%b out=%0d last=%b none=%b want 1 7 1 0",
                     b_out_valid, b_out, b_out_last, b_out_none);
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lsb_idle got vld=%b rdy=%b want 0 1", b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in = 8'h00;
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 3'd0 || a_out_none !== 1'b1 || a_out_last !== 1'b1) begin
            errors++;
            $display("FAIL zero_beat got vld=%b out=%0d none=%b last=%b want 1 0 1 1",
                     a_out_valid, a_out, a_out_none, a_out_last);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_none !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle got vld=%b none=%b rdy=%b want 0 0 1", a_out_valid, a_out_none, a_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in = 8'hFF;
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out !== 3'(7 - k) || a_out_last !== 1'b0) begin
                errors++;
                $display("FAIL abort_beat%0d got vld=%b out=%0d last=%b want 1 %0d 0",
                         k, a_out_valid, a_out, a_out_last, 7 - k);
            end
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_reset got vld=%b busy=%b rdy=%b want 0 0 1", a_out_valid, a_busy, a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard got vld=%b want 0", a_out_valid);
        end
        a_in_valid = 1'b1;
        a_in = 8'h10;
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out !== 3'd4 || a_out_last !== 1'b1) begin
            errors++;
            $display("FAIL abort_next got vld=%b out=%0d last=%b want 1 4 1", a_out_valid, a_out, a_out_last);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle got vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_wide();
        out_ready = 1'b1;
        c_in_valid = 1'b1;
        c_in = 16'h8001;
        @(negedge clk);
        c_in_valid = 1'b0;
        checks++;
        if (c_out_valid !== 1'b1 || c_out !== 4'd15 || c_out_last !== 1'b0) begin
            errors++;
            $display("FAIL wide_beat0 got vld=%b out=%0d last=%b want 1 15 0", c_out_valid, c_out, c_out_last);
        end
        @(negedge clk);
        checks++;
        if (c_out_valid !== 1'b1 || c_out !== 4'd0 || c_out_last !== 1'b1) begin
            errors++;
            $display("FAIL wide_beat1 got vld=%b out=%0d last=%b want 1 0 1", c_out_valid, c_out, c_out_last);
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            c_in_valid = 1'b1;
            c_in = 16'h0001 << i;
            @(negedge clk);
            c_in_valid = 1'b0;
            checks++;
            if (c_out_valid !== 1'b1 || c_out !== 4'(i) || c_out_last !== 1'b1 || c_out_none !== 1'b0) begin
                errors++;
                $display("FAIL onehot%0d got vld=%b out=%0d last=%b none=%b want 1 %0d 1 0",
                         i, c_out_valid, c_out, c_out_last, c_out_none, i);
            end
            @(negedge clk);
            checks++;
            if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL onehot%0d_idle got vld=%b rdy=%b want 0 1", i, c_out_valid, c_in_ready);
            end
        end
    endtask

    initial begin
        out_ready  = 1'b1;
        a_in_valid = 1'b0; a_in = '0;
        b_in_valid = 1'b0; b_in = '0;
        c_in_valid = 1'b0; c_in = '0;
        rst = 1'b1;
        test_reset();
        test_msb_first();
        test_ignore_in_emit();
        test_lsb_stall();
        test_zero();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
